// File: rtl/reset_sequencer.sv
// reset_sequencer: brings the processor system out of reset only after the PLL
// has reported lock continuously for LOCK_STABLE_CYCLES and a further
// HOLD_CYCLES have elapsed. Lock loss or a debounced push-button press sends the
// sequence back to WAIT_LOCK. The FSM state is exposed on state_o for checkers.
//
// Optional feature: define RESET_SEQUENCER_LOSS_CNT_EN to add lock_loss_cnt[7:0],
// a saturating count of RUN exits caused by PLL lock loss.
//
// No valid/ready handshakes: every input is a level sampled through a
// two-flop synchronizer, and every output is a registered level.
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 256,
  parameter int HOLD_CYCLES        = 1024,
  parameter int DEBOUNCE_CYCLES    = 65536
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       pll_locked,
  input  logic       key_n,
`ifdef RESET_SEQUENCER_LOSS_CNT_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic       sys_reset_n,
  output logic [1:0] state_o
);

  localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(LOCK_STABLE_CYCLES);
  localparam logic [HOLD_W-1:0]   HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
  localparam logic [DEB_W-1:0]    DEB_MAX    = DEB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                lock_meta;
  logic                lock_sync;
  logic                key_meta;
  logic                key_sync;
  logic [STABLE_W-1:0] stable_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DEB_W-1:0]    deb_cnt;
  logic                key_pressed;
  logic                run_d;
  logic                loss_event;

  // Two-flop synchronizers for the asynchronous lock and push-button inputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      key_meta  <= 1'b0;
      key_sync  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
      key_meta  <= key_n;
      key_sync  <= key_meta;
    end
  end

  // Debouncer: count consecutive low cycles, saturate; any high cycle clears.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      deb_cnt <= '0;
    end else if (key_sync) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_MAX) begin
      deb_cnt <= deb_cnt + DEB_W'(1);
    end
  end

  assign key_pressed = (deb_cnt == DEB_MAX);

  // Lock-stable counter: only runs in WAIT_LOCK, saturates, cleared by a low cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_cnt <= '0;
    end else if (state_q == ST_WAIT_LOCK && lock_sync) begin
      if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + STABLE_W'(1);
    end else begin
      stable_cnt <= '0;
    end
  end

  // Hold counter: only runs in HOLD while lock is held, saturates.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hold_cnt <= '0;
    end else if (state_q == ST_HOLD && lock_sync) begin
      if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= ST_RESET;
    else                state_q <= state_d;
  end

  // FSM next-state logic; lock loss is checked before the key press in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:     state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_sync && stable_cnt == STABLE_MAX && !key_pressed)
                      state_d = ST_HOLD;
      ST_HOLD:      if (!lock_sync)                state_d = ST_WAIT_LOCK;
                    else if (hold_cnt == HOLD_MAX) state_d = ST_RUN;
      ST_RUN:       if (!lock_sync || key_pressed) state_d = ST_WAIT_LOCK;
      default:      state_d = ST_RESET;
    endcase
  end

  // FSM outputs: debug state, registered-reset source and lock-loss event.
  always_comb begin
    state_o    = state_q;
    run_d      = (state_d == ST_RUN);
    loss_event = (state_q == ST_RUN) && !lock_sync;
  end

  // sys_reset_n follows next-state so it rises on the same edge RUN is entered.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) sys_reset_n <= 1'b0;
    else                sys_reset_n <= run_d;
  end

`ifdef RESET_SEQUENCER_LOSS_CNT_EN
  // Saturating count of RUN exits caused by lock loss.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      lock_loss_cnt <= 8'd0;
    end else if (loss_event && lock_loss_cnt != 8'hFF) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`else
  // Without the counter the lock-loss event has no consumer.
  logic unused_loss;
  assign unused_loss = loss_event;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer with small parameters
// (LOCK_STABLE_CYCLES=4, HOLD_CYCLES=8, DEBOUNCE_CYCLES=4).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled there.
// Index j in the loops counts rising edges, j=0 being the first edge that
// samples the new input value.
module tb_reset_sequencer;
  localparam int L = 4;
  localparam int H = 8;
  localparam int D = 4;

  // Clock / reset block
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll = 1'b0;
  logic       key = 1'b1;
  logic       sys_reset_n;
  logic [1:0] state_o;
`ifdef RESET_SEQUENCER_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .LOCK_STABLE_CYCLES(L),
    .HOLD_CYCLES(H),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .pll_locked(pll),
    .key_n(key),
`ifdef RESET_SEQUENCER_LOSS_CNT_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .sys_reset_n(sys_reset_n),
    .state_o(state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected state j edges after pll_locked is first sampled high from WAIT_LOCK.
  function automatic logic [1:0] seq_state(int j);
    if (j < L + 2)          return 2'd1;
    else if (j < L + H + 3) return 2'd2;
    else                    return 2'd3;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; pll = 1'b1; key = 1'b1;
    repeat (3) tick();
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (sys_reset_n !== 1'b0) begin bad++; $display("FAIL reset_sys got=%0b exp=0", sys_reset_n); end
    rst_n = 1'b1;
    for (int j = 0; j <= L + H + 3; j++) begin
      logic [1:0] es;
      tick();
      es = seq_state(j);
      total++; if (state_o !== es) begin bad++; $display("FAIL startup_state j=%0d got=%0d exp=%0d", j, state_o, es); end
      total++; if (sys_reset_n !== (es == 2'd3)) begin bad++; $display("FAIL startup_sys j=%0d got=%0b exp=%0b", j, sys_reset_n, es == 2'd3); end
    end
  endtask

  task automatic test_glitch();
    rst_n = 1'b0; pll = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    total++; if (state_o !== 2'd1) begin bad++; $display("FAIL glitch_wait got=%0d exp=1", state_o); end
    pll = 1'b1;
    for (int j = 0; j <= 19; j++) begin
      logic [1:0] es;
      tick();
      if (j == 2) pll = 1'b0;
      if (j == 3) pll = 1'b1;
      es = (j < 10) ? 2'd1 : (j < 19) ? 2'd2 : 2'd3;
      total++; if (state_o !== es) begin bad++; $display("FAIL glitch_state j=%0d got=%0d exp=%0d", j, state_o, es); end
      total++; if (sys_reset_n !== (es == 2'd3)) begin bad++; $display("FAIL glitch_sys j=%0d got=%0b exp=%0b", j, sys_reset_n, es == 2'd3); end
    end
  endtask

  task automatic test_lock_loss();
`ifdef RESET_SEQUENCER_LOSS_CNT_EN
    total++; if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL loss_cnt_before got=%0d exp=0", lock_loss_cnt); end
`endif
    pll = 1'b0;
    for (int j = 0; j <= 2; j++) begin
      logic [1:0] es;
      tick();
      es = (j < 2) ? 2'd3 : 2'd1;
      total++; if (state_o !== es) begin bad++; $display("FAIL loss_state j=%0d got=%0d exp=%0d", j, state_o, es); end
      total++; if (sys_reset_n !== (es == 2'd3)) begin bad++; $display("FAIL loss_sys j=%0d got=%0b exp=%0b", j, sys_reset_n, es == 2'd3); end
    end
`ifdef RESET_SEQUENCER_LOSS_CNT_EN
    total++; if (lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL loss_cnt_after got=%0d exp=1", lock_loss_cnt); end
`endif
  endtask

  task automatic test_hold_loss();
    pll = 1'b1;
    for (int j = 0; j <= 11; j++) begin
      logic [1:0] es;
      tick();
      if (j == 8) pll = 1'b0;
      es = (j < 6) ? 2'd1 : (j <= 10) ? 2'd2 : 2'd1;
      total++; if (state_o !== es) begin bad++; $display("FAIL hold_loss_state j=%0d got=%0d exp=%0d", j, state_o, es); end
      total++; if (sys_reset_n !== 1'b0) begin bad++; $display("FAIL hold_loss_sys j=%0d got=%0b exp=0", j, sys_reset_n); end
    end
    pll = 1'b1;
    for (int j = 0; j <= L + H + 3; j++) begin
      logic [1:0] es;
      tick();
      es = seq_state(j);
      total++; if (state_o !== es) begin bad++; $display("FAIL relock_state j=%0d got=%0d exp=%0d", j, state_o, es); end
      total++; if (sys_reset_n !== (es == 2'd3)) begin bad++; $display("FAIL relock_sys j=%0d got=%0b exp=%0b", j, sys_reset_n, es == 2'd3); end
    end
`ifdef RESET_SEQUENCER_LOSS_CNT_EN
    total++; if (lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL hold_loss_cnt got=%0d exp=1", lock_loss_cnt); end
`endif
  endtask

  task automatic test_key();
    // Three-cycle press: shorter than the debounce window, no effect.
    key = 1'b0;
    for (int j = 0; j <= 12; j++) begin
      tick();
      if (j == 2) key = 1'b1;
      total++; if (state_o !== 2'd3) begin bad++; $display("FAIL key_short_state j=%0d got=%0d exp=3", j, state_o); end
      total++; if (sys_reset_n !== 1'b1) begin bad++; $display("FAIL key_short_sys j=%0d got=%0b exp=1", j, sys_reset_n); end
    end
    // Six-cycle press: one exit, then a normal restart after release.
    key = 1'b0;
    for (int j = 0; j <= 20; j++) begin
      logic [1:0] es;
      tick();
      if (j == 5) key = 1'b1;
      es = (j < 6) ? 2'd3 : (j < 11) ? 2'd1 : (j < 20) ? 2'd2 : 2'd3;
      total++; if (state_o !== es) begin bad++; $display("FAIL key_six_state j=%0d got=%0d exp=%0d", j, state_o, es); end
      total++; if (sys_reset_n !== (es == 2'd3)) begin bad++; $display("FAIL key_six_sys j=%0d got=%0b exp=%0b", j, sys_reset_n, es == 2'd3); end
    end
    // Long press: HOLD stays blocked until the button is released.
    key = 1'b0;
    for (int j = 0; j <= 42; j++) begin
      logic [1:0] es;
      tick();
      if (j == 29) key = 1'b1;
      es = (j < 6) ? 2'd3 : (j < 33) ? 2'd1 : (j < 42) ? 2'd2 : 2'd3;
      total++; if (state_o !== es) begin bad++; $display("FAIL key_long_state j=%0d got=%0d exp=%0d", j, state_o, es); end
      total++; if (sys_reset_n !== (es == 2'd3)) begin bad++; $display("FAIL key_long_sys j=%0d got=%0b exp=%0b", j, sys_reset_n, es == 2'd3); end
    end
`ifdef RESET_SEQUENCER_LOSS_CNT_EN
    total++; if (lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL key_loss_cnt got=%0d exp=1", lock_loss_cnt); end
`endif
  endtask

  task automatic test_reset_mid_hold();
    rst_n = 1'b0; pll = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j <= 11; j++) begin
      logic [1:0] es;
      tick();
      es = seq_state(j);
      total++; if (state_o !== es) begin bad++; $display("FAIL mid_hold_state j=%0d got=%0d exp=%0d", j, state_o, es); end
    end
    rst_n = 1'b0;
    #1;
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL async_reset_state got=%0d exp=0", state_o); end
    total++; if (sys_reset_n !== 1'b0) begin bad++; $display("FAIL async_reset_sys got=%0b exp=0", sys_reset_n); end
`ifdef RESET_SEQUENCER_LOSS_CNT_EN
    total++; if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL async_reset_cnt got=%0d exp=0", lock_loss_cnt); end
`endif
    tick(); tick();
    rst_n = 1'b1;
    for (int j = 0; j <= L + H + 3; j++) begin
      logic [1:0] es;
      tick();
      es = seq_state(j);
      total++; if (state_o !== es) begin bad++; $display("FAIL restart_state j=%0d got=%0d exp=%0d", j, state_o, es); end
      total++; if (sys_reset_n !== (es == 2'd3)) begin bad++; $display("FAIL restart_sys j=%0d got=%0b exp=%0b", j, sys_reset_n, es == 2'd3); end
    end
  endtask

`ifdef RESET_SEQUENCER_LOSS_CNT_EN
  task automatic test_loss_saturation();
    for (int n = 1; n <= 260; n++) begin
      logic [7:0] exp_cnt;
      int w;
      pll = 1'b0;
      w = 0;
      while (state_o !== 2'd1 && w < 10) begin tick(); w++; end
      total++; if (state_o !== 2'd1) begin bad++; $display("FAIL sat_exit_timeout n=%0d got=%0d exp=1", n, state_o); break; end
      exp_cnt = (n > 255) ? 8'd255 : 8'(n);
      total++; if (lock_loss_cnt !== exp_cnt) begin bad++; $display("FAIL sat_cnt n=%0d got=%0d exp=%0d", n, lock_loss_cnt, exp_cnt); end
      pll = 1'b1;
      w = 0;
      while (state_o !== 2'd3 && w < 40) begin tick(); w++; end
      total++; if (state_o !== 2'd3) begin bad++; $display("FAIL sat_run_timeout n=%0d got=%0d exp=3", n, state_o); break; end
    end
    total++; if (lock_loss_cnt !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d exp=255", lock_loss_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_lock_loss();
    test_hold_loss();
    test_key();
    test_reset_mid_hold();
`ifdef RESET_SEQUENCER_LOSS_CNT_EN
    test_loss_saturation();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 256: consecutive synchronized-lock cycles required before leaving WAIT_LOCK.
REQ-002 SHALL have parameter HOLD_CYCLES, default 1024: cycles sys_reset_n is held low after lock is stable.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 65536: consecutive synchronized-low cycles on key_n that constitute a press.
REQ-004 SHALL have port clk_clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_reset_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port pll_locked, input, 1: asynchronous PLL lock indication, driven by the processor system's altpll_0_locked_conduit_export.
REQ-007 SHALL have port key_n, input, 1: asynchronous soft-reset push-button, active-low, bouncing.
REQ-008 SHALL have port sys_reset_n, output, 1: registered reset feeding the processor system's reset_reset_n; high only in RUN.
REQ-009 SHALL have port state_o, output, 2: current FSM state encoding.

Function
REQ-010 SHALL synchronize pll_locked and key_n through two flip-flops each before any use.
REQ-011 SHALL implement FSM states RESET=0, WAIT_LOCK=1, HOLD=2, RUN=3; state_o equals the state register.
REQ-012 RESET SHALL last exactly one cycle after reset_reset_n deasserts, then go to WAIT_LOCK.
REQ-013 WAIT_LOCK: stable counter increments each cycle the synced lock is high and clears on any low cycle; SHALL go to HOLD on the cycle the count reaches LOCK_STABLE_CYCLES, but only if debounced key is released.
REQ-014 HOLD: hold counter increments per cycle; SHALL go to RUN on the cycle the count reaches HOLD_CYCLES; synced lock low in HOLD SHALL return to WAIT_LOCK with both counters cleared.
REQ-015 RUN: synced lock low or a debounced key press SHALL return to WAIT_LOCK; lock loss takes priority when both occur in the same cycle.
REQ-016 sys_reset_n SHALL be registered from next-state==RUN; with pll_locked already high, it rises exactly LOCK_STABLE_CYCLES+HOLD_CYCLES+3 cycles after pll_locked rises.
REQ-017 In RUN, a pll_locked falling edge SHALL drive sys_reset_n low no later than 3 cycles later.
REQ-018 Debouncer: counter counts consecutive synced-low key_n cycles, saturates at DEBOUNCE_CYCLES; pressed=1 when saturated; any high cycle clears counter and pressed.
REQ-019 A key press SHALL cause exactly one RUN exit per press; re-entry to HOLD is blocked until pressed=0.
REQ-020 Counter widths SHALL be $clog2(param+1); counters SHALL never wrap.

Reset
REQ-021 reset_reset_n low SHALL asynchronously force state=RESET, sys_reset_n=0, state_o=0, all counters and synchronizers to 0, pressed=0.
REQ-022 Reset asserted mid-HOLD or mid-RUN SHALL restart the full sequence; no partial count survives.

Configuration
REQ-023 Macro RESET_SEQUENCER_LOSS_CNT_EN SHALL, when defined, add output lock_loss_cnt[7:0]: increments on each RUN->WAIT_LOCK transition caused by lock loss, saturates at 255, cleared only by reset_reset_n.
REQ-024 Without RESET_SEQUENCER_LOSS_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification (bench params LOCK_STABLE_CYCLES=4, HOLD_CYCLES=8, DEBOUNCE_CYCLES=4)
REQ-025 Release reset with pll_locked=1 held -> state 0,1,2,3 sequence; sys_reset_n high 15 cycles after pll_locked first seen high.
REQ-026 pll_locked glitches low 1 cycle during WAIT_LOCK count=3 -> counter clears; HOLD entered 4 synced-high cycles after the glitch.
REQ-027 In RUN, drop pll_locked -> sys_reset_n low within 3 cycles, state_o=1; with macro defined lock_loss_cnt 0->1.
REQ-028 In RUN, key_n low 3 cycles then high -> no effect; key_n low 6 cycles -> single exit to WAIT_LOCK, HOLD not entered until key_n high.
REQ-029 Assert reset_reset_n mid-HOLD (count=5) -> immediately sys_reset_n=0, state_o=0; after release the full 15-cycle sequence repeats.
REQ-030 Macro defined, 260 forced lock losses from RUN -> lock_loss_cnt saturates at 255.
